// File: rtl/ahb_lite_cmd_master_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master_if
// Bundles the command/response stream and the AHB-Lite bus signals used by
// ahb_lite_cmd_master.
//   master modport : the command master itself (drives HADDR/HTRANS/...,
//                    cmd_ready and the rsp_* stream).
//   slave modport  : the environment side (command source, response sink and
//                    AHB-Lite slave).
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_size/cmd_wdata : command stream
//   rsp_valid/rsp_rdata/rsp_error                             : response pulse
//   HADDR/HWRITE/HTRANS/HSIZE/HBURST/HPROT/HWDATA              : AHB outputs
//   HREADY/HRDATA/HRESP                                       : AHB inputs
// ---------------------------------------------------------------------------
interface ahb_lite_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
// Single-transfer AHB-Lite master: each accepted command becomes one NONSEQ
// transfer and produces exactly one rsp_valid pulse. Address and data phases
// are pipelined, so back-to-back commands run at one transfer per cycle.
// Handles wait states and the two-cycle ERROR response (the pending address
// phase is cancelled to IDLE and reissued afterwards).
// Ports:
//   HCLK    : clock, rising edge
//   HRESET  : synchronous active-high reset
//   bus     : ahb_lite_cmd_master_if.master (command, response, AHB bus)
// Parameter:
//   HPROT_VAL : constant value driven on HPROT
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  ahb_lite_cmd_master_if.master       bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Size code 3 is not a legal single-beat size here; it is folded to word.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a,
                                             input logic [1:0]  s);
    logic [31:0] r;
    case (s)
      2'd1:    r = {a[31:1], 1'b0};
      2'd2:    r = {a[31:2], 2'b00};
      default: r = a;
    endcase
    return r;
  endfunction

  // Address-phase slot
  logic        vld_p0;
  logic [31:0] addr_p0;
  logic        write_p0;
  logic [1:0]  size_p0;
  logic [31:0] wdata_p0;

  // Data-phase slot
  logic        vld_p1;
  logic        write_p1;
  logic [31:0] hwdata_p1;

  // Response
  logic        rsp_vld_p2;
  logic [31:0] rsp_rdata_p2;
  logic        rsp_error_p2;

  // Set during the second ERROR cycle: forces IDLE and holds the ap slot.
  logic        cancel;

  logic        cmd_ready_w;
  logic        accept;
  logic        ap_go;
  logic        dp_go;
  logic [1:0]  cmd_size_eff;

  assign cmd_size_eff = eff_size(bus.cmd_size);
  assign cmd_ready_w  = !vld_p0 || (bus.HREADY && !cancel);
  assign accept       = bus.cmd_valid && cmd_ready_w;
  assign ap_go        = vld_p0 && !cancel && bus.HREADY;
  assign dp_go        = vld_p1 && bus.HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p0       <= 1'b0;
      addr_p0      <= '0;
      write_p0     <= 1'b0;
      size_p0      <= '0;
      wdata_p0     <= '0;
      vld_p1       <= 1'b0;
      write_p1     <= 1'b0;
      hwdata_p1    <= '0;
      cancel       <= 1'b0;
      rsp_vld_p2   <= 1'b0;
      rsp_rdata_p2 <= '0;
      rsp_error_p2 <= 1'b0;
    end else begin
      // ---- command -> address phase ----
      if (accept) begin
        vld_p0   <= 1'b1;
        addr_p0  <= align_addr(bus.cmd_addr, cmd_size_eff);
        write_p0 <= bus.cmd_write;
        size_p0  <= cmd_size_eff;
        wdata_p0 <= bus.cmd_wdata;
      end else if (ap_go) begin
        vld_p0   <= 1'b0;
      end

      // ---- address phase -> data phase ----
      if (ap_go) begin
        vld_p1    <= 1'b1;
        write_p1  <= write_p0;
        hwdata_p1 <= wdata_p0;
      end else if (dp_go) begin
        vld_p1    <= 1'b0;
      end

      if (bus.HREADY)
        cancel <= 1'b0;
      else if (vld_p1 && bus.HRESP)
        cancel <= 1'b1;

      // ---- data phase -> response ----
      rsp_vld_p2 <= dp_go;
      if (dp_go) begin
        rsp_error_p2 <= bus.HRESP;
        rsp_rdata_p2 <= write_p1 ? 32'h0 : bus.HRDATA;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.HTRANS    = (vld_p0 && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = addr_p0;
  assign bus.HWRITE    = write_p0;
  assign bus.HSIZE     = {1'b0, size_p0};
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = hwdata_p1;
  assign bus.rsp_valid = rsp_vld_p2;
  assign bus.rsp_rdata = rsp_rdata_p2;
  assign bus.rsp_error = rsp_error_p2;

endmodule

// File: doc/ahb_lite_cmd_master.md
# ahb_lite_cmd_master

Single-transfer AHB-Lite master (initiator) that turns a simple valid/ready command stream into pipelined AHB-Lite NONSEQ transfers and returns one response per command. It drives the memory subsystem slave side of the AHB interface, for bench traffic generation and for on-chip control logic. It supports wait states, the two-cycle ERROR response with address-phase cancellation, and back-to-back transfers at one per cycle.

## Interface
- HPROT_VAL, default 4'b0011, constant driven on HPROT (data, privileged)
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
- cmd_addr  in  32  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  0 byte, 1 halfword, 2 word; 3 treated as 2
- cmd_wdata  in  32  write data, lane-placed by the caller
- rsp_valid  out  1  one-cycle pulse per completed transfer, no backpressure
- rsp_rdata  out  32  HRDATA captured at read completion; 0 for writes
- rsp_error  out  1  transfer ended with ERROR
- HADDR  out  32  address phase
- HWRITE  out  1
- HTRANS  out  2  IDLE 2'b00 or NONSEQ 2'b10 only
- HSIZE  out  3  {1'b0, effective size}
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant HPROT_VAL
- HWDATA  out  32  data phase
- HREADY  in  1  transfer/phase completion
- HRDATA  in  32
- HRESP  in  1  0 OKAY, 1 ERROR

## Operation
- Two flop stages:
  - Address-phase slot (ap_valid, addr, write, size, wdata).
  - Data-phase slot (dp_valid, write).
- HTRANS = NONSEQ when ap_valid && !cancel, otherwise IDLE. HADDR, HWRITE and HSIZE come from the ap slot.
- HADDR low bits are masked to the effective size: size 1 clears bit 0, size 2 clears bits 1:0.
- cmd_ready = !ap_valid || (HREADY && !cancel).
- On an accepting edge, the ap slot loads the command.
- Address-phase completion is an edge with ap_valid && !cancel && HREADY:
  - dp slot loads dp_valid=1 and the write flag.
  - HWDATA loads ap wdata.
  - The ap slot clears unless a new command is accepted on the same edge.
- Data-phase completion is an edge with dp_valid && HREADY:
  - rsp_valid=1 on the next cycle.
  - rsp_error = HRESP.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - dp_valid clears unless a new address phase completes on the same edge.
- ERROR handling:
  - When dp_valid && !HREADY && HRESP, set cancel=1.
  - While cancel=1, HTRANS is IDLE, the pending ap slot is held and not transferred, and cmd_ready=0 if ap_valid.
  - cancel clears on the edge where HREADY=1.
  - The held command is reissued as NONSEQ on the following cycle.
- Reset, synchronous, on an edge with HRESET=1:
  - ap_valid, dp_valid and cancel go to 0.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, cmd_ready=1.
  - In-flight transfers are dropped and no response is issued for them.

## Timing
- Zero-wait single transfer:
  - C0: command accepted.
  - C1: NONSEQ address phase.
  - C2: data phase with HWDATA valid.
  - C3: rsp_valid.
  - Command-to-response latency is 3 cycles plus the number of wait states.
- Back-to-back commands with HREADY=1 give one address phase per cycle and one rsp_valid per cycle.
- A wait state (HREADY=0) freezes HADDR, HTRANS and HWDATA. cmd_ready is 0 while ap_valid.
- ERROR: cycle E1 has HREADY=0, HRESP=1. Cycle E2 has HTRANS=IDLE with HREADY=1, HRESP=1. The rsp_error pulse follows E2.
- HBURST and HPROT are constant out of reset.

## Test plan
- Reset: hold HRESET=1 for 2 cycles mid-transfer -> all outputs at reset values, HTRANS=IDLE, no rsp_valid afterward.
- Single write: addr 0x0000_0010, size 2, data 0xDEAD_BEEF, HREADY=1 -> NONSEQ at C1 with HADDR=0x10, HWRITE=1, HSIZE=3'b010; HWDATA=0xDEADBEEF at C2; rsp_valid at C3 with rsp_error=0.
- Four back-to-back reads from 0x0, 0x4, 0x8, 0xC, with the slave returning addr+0x100 -> four consecutive NONSEQ cycles and four consecutive rsp pulses with rdata 0x100, 0x104, 0x108, 0x10C.
- Wait states: read 0x20 with 3 HREADY=0 cycles in the data phase, second command pending -> HADDR=next address held stable for 3 cycles, rsp_valid at C6.
- ERROR: write 0x40 answered ERROR, next read 0x44 pending -> HTRANS=IDLE in E2, rsp_error=1 for the write, then 0x44 reissued as NONSEQ and completes OKAY.
- Size/masking: cmd_size=1 with addr 0x13 -> HADDR=0x12; cmd_size=3 with addr 0x17 -> HSIZE=3'b010, HADDR=0x14.
